program_counter: RTL and testbench
==================================

# program_counter

Instruction-address register at the front of the pipeline's fetch stage. Each cycle it advances the program counter by one, or loads a jump target, and drives the current address to the instruction ROM and the debugging unit. It also exposes the sequential successor address for link or return-address use. All state is one register updated on the rising clock edge.

## Interface
Parameters:
- ADDR_WIDTH, 10, width of the program counter and the jump address.
- RESET_ADDR, 0, value loaded on reset and at power-up/initialisation.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous and active-high.
- stall  input  1  hold request from the hazard logic; high freezes the PC.
- jump_flag  input  1  high means take a jump this cycle.
- jump_addr  input  ADDR_WIDTH  jump target address, unsigned absolute.
- PC_reg  output  ADDR_WIDTH  current program counter (registered), feeds the ROM address and the debugging unit.
- PC_plus1  output  ADDR_WIDTH  combinational PC_reg + 1, modulo 2^ADDR_WIDTH.

## Operation
The register update at each rising clk edge uses this priority, highest first:
1. reset = 1: PC_reg <= RESET_ADDR. This overrides everything.
2. jump_flag = 1: PC_reg <= jump_addr. A jump wins over stall, so a control transfer is never lost.
3. stall = 1: PC_reg holds its value.
4. Otherwise: PC_reg <= PC_reg + 1.

Arithmetic and initial-value rules:
- The increment is unsigned and wraps from 2^ADDR_WIDTH − 1 to 0 with no flag.
- PC_plus1 uses the same wrap rule.
- The register's initial value, before the first reset, is RESET_ADDR. This applies to both simulation and FPGA configuration, so the PC is never X or undefined.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect.
- jump_addr is ignored whenever jump_flag = 0.

## Timing
- Latency is one cycle. Inputs present before edge N are reflected on PC_reg immediately after edge N.
- PC_plus1 follows PC_reg combinationally within the same cycle.
- Reset asserted mid-run takes effect at the next edge. While reset stays high, PC_reg remains RESET_ADDR.
- The first edge after reset deasserts applies normal priority. With no jump or stall, that gives RESET_ADDR + 1.
- If jump_flag is held for k consecutive edges with a constant target, PC_reg equals jump_addr after each of those edges. It does not increment.
- When jump_flag and stall are both high, the jump target is loaded on that edge.
- A jump to the current PC value is legal and reloads the same value.

## Structure
- Shared package holds:
  - the PC width constant (10) and the reset vector constant (0);
  - a pc_t typedef of that width, used by fetch, ROM, branch unit and debugging unit.
- A single flat module with no sub-modules. The next-PC multiplexer and incrementer are inline combinational logic feeding one register.

## Test plan
- Power-up/free run: clk period 20 ns, no reset, stall = 0, jump = 0. PC_reg = 0, then 1, 2, 3, 4, 5 after successive edges.
- Single-cycle jump: after PC reaches 5, pulse jump_flag = 1 with jump_addr = 3 for one edge. PC_reg = 3, then 4, 5 on following edges.
- Synchronous reset: with PC = 7, raise reset for two edges. PC_reg = 0 after the first edge and stays 0. After release, PC_reg goes 1, 2.
- Stall and jump-over-stall:
  - stall = 1 for three edges at PC = 4: PC_reg stays 4.
  - stall = 1 with jump_flag = 1 and jump_addr = 0x200: PC_reg = 0x200.
  - After release: PC_reg = 0x201.
- Wrap-around: jump to 0x3FF, then increment. PC_reg = 0x3FF with PC_plus1 = 0x000, and the next edge gives PC_reg = 0x000.
- Reset beats jump: reset = 1 and jump_flag = 1 with jump_addr = 0x155 on the same edge. PC_reg = 0.

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared fetch-stage types: PC width, reset vector and the address type
// used by fetch, ROM, branch unit and debugging unit.
package program_counter_pkg;

    localparam int unsigned PC_WIDTH = 10;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t PC_RESET = '0;

endpackage : program_counter_pkg

// File: rtl/program_counter.sv
// Fetch-stage instruction-address register. Each cycle the PC either reloads
// the reset vector, loads a jump target, holds on stall, or advances by one.
// PC_plus1 exposes the sequential successor for link/return-address use.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = PC_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR = ADDR_WIDTH'(PC_RESET)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  jump_flag,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [ADDR_WIDTH-1:0] PC_reg,
    output logic [ADDR_WIDTH-1:0] PC_plus1
);

    // Declaration initialiser gives a defined PC before the first reset,
    // both in simulation and in the FPGA configuration bitstream.
    logic [ADDR_WIDTH-1:0] pc_q = RESET_ADDR;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Unsigned increment, wraps modulo 2^ADDR_WIDTH with no carry out.
    always_comb begin
        pc_inc = pc_q + ADDR_WIDTH'(1);
    end

    // Next-PC select: jump beats stall so a control transfer is never lost.
    always_comb begin
        pc_d = pc_q;
        if (jump_flag) begin
            pc_d = jump_addr;
        end else if (!stall) begin
            pc_d = pc_inc;
        end
    end

    // PC register with synchronous active-high reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC_reg   = pc_q;
    assign PC_plus1 = pc_inc;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter: power-up run, jumps,
// synchronous reset, stall, jump-over-stall, wrap-around and reset priority.
module tb_program_counter;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          jump_flag = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic [AW-1:0] PC_reg;
    logic [AW-1:0] PC_plus1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    program_counter #(
        .ADDR_WIDTH (AW),
        .RESET_ADDR (10'h000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .jump_flag (jump_flag),
        .jump_addr (jump_addr),
        .PC_reg    (PC_reg),
        .PC_plus1  (PC_plus1)
    );

    // 20 ns clock period.
    always #10 clk = ~clk;

    // Compares PC_reg and PC_plus1 against hand-computed values.
    task automatic check(input string tag, input logic [AW-1:0] exp_pc,
                         input logic [AW-1:0] exp_p1);
        n_cmp++;
        assert (PC_reg === exp_pc) else begin
            n_bad++;
            $error("FAIL %s PC_reg observed=%h expected=%h", tag, PC_reg, exp_pc);
        end
        n_cmp++;
        assert (PC_plus1 === exp_p1) else begin
            n_bad++;
            $error("FAIL %s PC_plus1 observed=%h expected=%h", tag, PC_plus1, exp_p1);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-up value without any reset, then free run.
        #5;
        check("powerup", 10'h000, 10'h001);
        step(); check("run1", 10'h001, 10'h002);
        step(); check("run2", 10'h002, 10'h003);
        step(); check("run3", 10'h003, 10'h004);
        step(); check("run4", 10'h004, 10'h005);
        step(); check("run5", 10'h005, 10'h006);

        // Single-cycle jump back to 3.
        jump_flag = 1'b1; jump_addr = 10'h003;
        step(); jump_flag = 1'b0;
        check("jump3", 10'h003, 10'h004);
        step(); check("after_jump4", 10'h004, 10'h005);
        step(); check("after_jump5", 10'h005, 10'h006);
        step(); check("run6", 10'h006, 10'h007);
        step(); check("run7", 10'h007, 10'h008);

        // Synchronous reset held two edges, then release.
        reset = 1'b1;
        step(); check("reset_e1", 10'h000, 10'h001);
        step(); check("reset_e2", 10'h000, 10'h001);
        reset = 1'b0;
        step(); check("post_reset1", 10'h001, 10'h002);
        step(); check("post_reset2", 10'h002, 10'h003);
        step(); check("run3b", 10'h003, 10'h004);
        step(); check("run4b", 10'h004, 10'h005);

        // Stall three edges at PC = 4.
        stall = 1'b1;
        step(); check("stall1", 10'h004, 10'h005);
        step(); check("stall2", 10'h004, 10'h005);
        step(); check("stall3", 10'h004, 10'h005);

        // Jump wins over stall.
        jump_flag = 1'b1; jump_addr = 10'h200;
        step(); check("jump_over_stall", 10'h200, 10'h201);
        jump_flag = 1'b0; stall = 1'b0;
        step(); check("release", 10'h201, 10'h202);

        // jump_addr is ignored while jump_flag is low.
        jump_addr = 10'h2AA;
        step(); check("addr_ignored", 10'h202, 10'h203);

        // Wrap-around at the top of the address space.
        jump_flag = 1'b1; jump_addr = 10'h3FF;
        step(); jump_flag = 1'b0;
        check("top", 10'h3FF, 10'h000);
        step(); check("wrap", 10'h000, 10'h001);

        // Jump to the current PC reloads the same value.
        jump_flag = 1'b1; jump_addr = 10'h000;
        step(); check("jump_self", 10'h000, 10'h001);

        // Jump held for three edges with a constant target never increments.
        jump_addr = 10'h010;
        step(); check("jump_hold1", 10'h010, 10'h011);
        step(); check("jump_hold2", 10'h010, 10'h011);
        step(); check("jump_hold3", 10'h010, 10'h011);
        jump_flag = 1'b0;
        step(); check("jump_hold_rel", 10'h011, 10'h012);

        // Reset beats a simultaneous jump.
        reset = 1'b1; jump_flag = 1'b1; jump_addr = 10'h155;
        step(); check("reset_over_jump", 10'h000, 10'h001);
        reset = 1'b0; jump_flag = 1'b0;
        step(); check("post_reset_jump", 10'h001, 10'h002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound on total runtime so the bench cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_program_counter
